cflog_tx_streamer: RTL and testbench

- Parametrised successor to the single-word CF-log UART controller.
- On a start pulse (acfa_nmi), reads a run of WORD_W-bit log entries from a synchronous log RAM and splits each entry into bytes.
- Pushes each byte to omsp_uart through the data_tx_wr/tx_byte port with the tx_triggered/tx_done handshake.
- Sits between the CF-log buffer and omsp_uart.

---
 rtl/cflog_pkg.sv | 22 ++
 rtl/cflog_byte_sel.sv | 16 +
 rtl/cflog_tx_streamer.sv | 179 +++++++++++++++++
 tb/tb_cflog_tx_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cflog_pkg.sv
// Shared types and helpers for the CF-log UART byte streamer.
package cflog_pkg;

    typedef enum logic [3:0] {
        IDLE, HDR, READ, LATCH, SEND, WAIT_TRIG, WAIT_DONE, NEXT, CKSUM, FIN
    } state_t;

    // Source of the byte currently presented on tx_byte (framed builds only).
    typedef enum logic [1:0] {K_PAY, K_SYNC, K_CNT, K_CK} kind_t;

    localparam logic [7:0] CFLOG_SYNC = 8'hA5;

    function automatic logic [7:0] byte_pick(input logic [63:0] word,
                                             input logic [3:0]  nb,
                                             input logic [2:0]  idx,
                                             input logic        msb_first);
        logic [2:0] pos;
        pos = msb_first ? 3'(nb - 4'd1 - {1'b0, idx}) : idx;
        return word[{pos, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cflog_byte_sel.sv
// Combinational byte mux: picks byte idx of a log entry in transmit order.
module cflog_byte_sel
    import cflog_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int MSB_FIRST = 1,
    parameter int IDX_W     = 1
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [7:0]        sel
);

    assign sel = byte_pick(64'(word), 4'(WORD_W / 8), 3'(idx), MSB_FIRST != 0);

endmodule

// File: rtl/cflog_tx_streamer.sv
// Streams a run of log RAM entries byte-by-byte into omsp_uart.
// Build option CFLOG_FRAME_EN adds an A5/count header and an XOR checksum trailer.
module cflog_tx_streamer
    import cflog_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              puc_rst_n,
    input  logic              acfa_nmi,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic              data_tx_wr,
    output logic [7:0]        tx_byte,
    input  logic              tx_triggered,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    localparam int NB    = WORD_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   rem;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  shreg;
    logic [TMO_W-1:0]   tcnt;
    logic [7:0]         sel_byte;
    logic               in_wait, tmo_hit, last_byte, more_words, pay_phase;

    cflog_byte_sel #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_sel (
        .word (shreg),
        .idx  (idx),
        .sel  (sel_byte)
    );

    assign in_wait    = (state == WAIT_TRIG) || (state == WAIT_DONE);
    assign tmo_hit    = (tcnt == TMO_MAX);
    assign last_byte  = (idx == LAST_IDX);
    assign more_words = (rem > CNT_W'(1));

    assign rd_en      = (state == READ);
    assign rd_addr    = addr;
    assign data_tx_wr = (state == SEND);
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

`ifdef CFLOG_FRAME_EN
    kind_t      kind;
    logic [7:0] cksum;
    localparam state_t PAY_END = CKSUM;

    assign pay_phase = (kind == K_PAY);

    always_comb begin
        case (kind)
            K_SYNC:  tx_byte = CFLOG_SYNC;
            K_CNT:   tx_byte = 8'(rem);
            K_CK:    tx_byte = cksum;
            default: tx_byte = sel_byte;
        endcase
    end

    always_ff @(posedge clk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            kind  <= K_PAY;
            cksum <= '0;
        end else if (state != IDLE && state_n == IDLE) begin
            kind <= K_PAY;
        end else begin
            case (state)
                IDLE:  if (acfa_nmi) begin kind <= K_SYNC; cksum <= '0; end
                SEND:  if (kind == K_PAY) cksum <= cksum ^ tx_byte;
                NEXT:  if (kind == K_SYNC) kind <= K_CNT;
                       else if (kind == K_CNT) kind <= K_PAY;
                CKSUM: kind <= K_CK;
                default: ;
            endcase
        end
    end
`else
    localparam state_t PAY_END = FIN;

    assign pay_phase = 1'b1;
    assign tx_byte   = sel_byte;
`endif

    always_ff @(posedge clk or negedge puc_rst_n) begin
        if (!puc_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (acfa_nmi) begin
`ifdef CFLOG_FRAME_EN
                state_n = HDR;
`else
                state_n = (word_count == '0) ? FIN : READ;
`endif
            end
            HDR:   state_n = SEND;
            READ:  state_n = LATCH;
            LATCH: state_n = SEND;
            SEND:  state_n = WAIT_TRIG;
            WAIT_TRIG: begin
                if (tx_triggered) state_n = tx_done ? NEXT : WAIT_DONE;
                else if (tmo_hit) state_n = IDLE;
            end
            WAIT_DONE: begin
                if (tx_done)      state_n = NEXT;
                else if (tmo_hit) state_n = IDLE;
            end
            NEXT: begin
`ifdef CFLOG_FRAME_EN
                if (kind == K_SYNC)     state_n = HDR;
                else if (kind == K_CNT) state_n = (rem == '0) ? CKSUM : READ;
                else if (kind == K_CK)  state_n = FIN;
                else
`endif
                if (!last_byte)      state_n = SEND;
                else if (more_words) state_n = READ;
                else                 state_n = PAY_END;
            end
            CKSUM:   state_n = SEND;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            addr        <= '0;
            rem         <= '0;
            idx         <= '0;
            shreg       <= '0;
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= in_wait && tmo_hit && (state_n == IDLE);
            // Timeout window restarts on every entry into a wait state.
            if (state_n != state)        tcnt <= '0;
            else if (in_wait && !tmo_hit) tcnt <= tcnt + TMO_W'(1);
            case (state)
                IDLE: if (acfa_nmi) begin
                    addr <= base_addr;
                    rem  <= word_count;
                end
                LATCH: begin
                    shreg <= rd_data;
                    idx   <= '0;
                end
                NEXT: if (pay_phase) begin
                    if (!last_byte) idx <= idx + IDX_W'(1);
                    else if (more_words) begin
                        rem  <= rem - CNT_W'(1);
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cflog_tx_streamer.sv
// Randomized self-checking bench: RAM + UART models, byte-list reference model.
module tb_cflog_tx_streamer;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 4;
    localparam int MSB_FIRST = 1;
    localparam int TO = 20;
    localparam int NB = WORD_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              puc_rst_n, acfa_nmi;
    logic [ADDR_W-1:0] base_addr, rd_addr;
    logic [ADDR_W:0]   word_count;
    logic              rd_en, data_tx_wr, tx_triggered, tx_done, busy, done, err_timeout;
    logic [WORD_W-1:0] rd_data;
    logic [7:0]        tx_byte;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [7:0]        got[$], exp_bytes[$];
    int                got_addrs[$], exp_addrs[$];
    int n_chk = 0, n_err = 0;
    int cyc = 0, done_cnt, err_cnt, wr_cnt, first_wr_cyc, trig_cyc, err_cyc, nmi_cyc;
    int ust = 0, ucnt = 0, trig_dly = 1, done_dly = 2;
    logic hang_done = 1'b0, busy_at_err;

    cflog_tx_streamer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MSB_FIRST(MSB_FIRST),
                        .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .puc_rst_n(puc_rst_n), .acfa_nmi(acfa_nmi), .base_addr(base_addr),
        .word_count(word_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .data_tx_wr(data_tx_wr), .tx_byte(tx_byte), .tx_triggered(tx_triggered),
        .tx_done(tx_done), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // UART handshake model plus output monitor.
    always @(negedge clk) begin
        tx_triggered = 1'b0;
        tx_done      = 1'b0;
        if (!puc_rst_n) ust = 0;
        else begin
            if (done) done_cnt++;
            if (err_timeout) begin err_cnt++; err_cyc = cyc; busy_at_err = busy; end
            if (rd_en) got_addrs.push_back(int'(rd_addr));
            if (ust != 0 && busy) begin
                chk("tx_hold", tx_byte, got[$]);
                chk("wr_one_cycle", data_tx_wr, 1'b0);
            end
            case (ust)
                0: if (data_tx_wr) begin
                    if (wr_cnt == 0) first_wr_cyc = cyc;
                    wr_cnt++;
                    got.push_back(tx_byte);
                    ucnt = trig_dly;
                    ust  = 1;
                end
                1: if (ucnt == 0) begin
                    tx_triggered = 1'b1;
                    trig_cyc = cyc;
                    if (hang_done) ust = 2;
                    else if (done_dly == 0) begin tx_done = 1'b1; ust = 0; end
                    else begin ucnt = done_dly - 1; ust = 2; end
                end else ucnt--;
                default: if (!hang_done) begin
                    if (ucnt == 0) begin tx_done = 1'b1; ust = 0; end
                    else ucnt--;
                end
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic build_exp(input int b, input int c);
        logic [WORD_W-1:0] w;
        logic [7:0] bt, x;
        int a, sh;
        exp_bytes.delete();
        exp_addrs.delete();
        x = 8'h00;
`ifdef CFLOG_FRAME_EN
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'(c));
`endif
        for (int k = 0; k < c; k++) begin
            a = (b + k) % DEPTH;
            exp_addrs.push_back(a);
            w = mem[a];
            for (int i = 0; i < NB; i++) begin
                sh = (MSB_FIRST != 0) ? (NB - 1 - i) : i;
                bt = 8'(w >> (8 * sh));
                exp_bytes.push_back(bt);
                x ^= bt;
            end
        end
`ifdef CFLOG_FRAME_EN
        exp_bytes.push_back(x);
`endif
    endtask

    task automatic start_xfer(input int b, input int c);
        got.delete();
        got_addrs.delete();
        done_cnt = 0; err_cnt = 0; wr_cnt = 0;
        base_addr  = ADDR_W'(b);
        word_count = (ADDR_W + 1)'(c);
        acfa_nmi   = 1'b1;
        nmi_cyc    = cyc;
        tick();
        acfa_nmi   = 1'b0;
        base_addr  = ADDR_W'($urandom);
        word_count = (ADDR_W + 1)'($urandom_range(1, 7));
    endtask

    task automatic wait_end(input int poke);
        int k;
        k = 0;
        while (done_cnt == 0 && err_cnt == 0 && k < 3000) begin
            acfa_nmi = (k == poke);
            if (k == poke) begin base_addr = 4'd9; word_count = 5'd1; end
            tick();
            k++;
        end
        acfa_nmi = 1'b0;
        chk("xfer_end", (done_cnt + err_cnt) > 0, 1'b1);
    endtask

    task automatic run_xfer(input int b, input int c, input int poke);
        build_exp(b, c);
        start_xfer(b, c);
        wait_end(poke);
        repeat (4) tick();
        chk("done_cnt", done_cnt, 1);
        chk("err_cnt", err_cnt, 0);
        chk("busy_after", busy, 1'b0);
        chk("wr_cnt", wr_cnt, exp_bytes.size());
        chk("n_bytes", got.size(), exp_bytes.size());
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
            chk($sformatf("byte%0d", i), got[i], exp_bytes[i]);
        chk("n_addrs", got_addrs.size(), exp_addrs.size());
        for (int i = 0; i < got_addrs.size() && i < exp_addrs.size(); i++)
            chk($sformatf("addr%0d", i), got_addrs[i], exp_addrs[i]);
    endtask

    task automatic chk_outs_zero();
        chk("z_rd_en", rd_en, 1'b0);
        chk("z_rd_addr", rd_addr, '0);
        chk("z_wr", data_tx_wr, 1'b0);
        chk("z_tx_byte", tx_byte, 8'h00);
        chk("z_busy", busy, 1'b0);
        chk("z_done", done, 1'b0);
        chk("z_err", err_timeout, 1'b0);
    endtask

    initial begin
        puc_rst_n = 1'b0; acfa_nmi = 1'b0; base_addr = '0; word_count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = WORD_W'($urandom);
        repeat (3) tick();
        chk_outs_zero();
        puc_rst_n = 1'b1;
        tick();

        // Single word, fixed 4-cycle UART answer
        mem[0] = 16'hABCD;
        trig_dly = 1; done_dly = 2;
        run_xfer(0, 1, -1);
`ifdef CFLOG_FRAME_EN
        if (got.size() == 5) begin
            chk("frm_sync", got[0], 8'hA5);
            chk("frm_cnt", got[1], 8'h01);
            chk("frm_b0", got[2], 8'hAB);
            chk("frm_b1", got[3], 8'hCD);
            chk("frm_ck", got[4], 8'h66);
        end
`else
        if (got.size() == 2) begin
            chk("t1_b0", got[0], 8'hAB);
            chk("t1_b1", got[1], 8'hCD);
        end
        chk("first_wr_lat", first_wr_cyc - nmi_cyc, 3);
`endif

        // Address wrap 15 -> 0 -> 1
        run_xfer(15, 3, -1);

        repeat (6) begin
            trig_dly = $urandom_range(0, 3);
            done_dly = $urandom_range(0, 4);
            run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 5), -1);
        end

        run_xfer(3, 0, -1);

        // Start pulse while busy must be ignored and not queued
        trig_dly = 2; done_dly = 2;
        run_xfer(2, 2, 8);
        repeat (5) tick();
        chk("nmi_not_queued", busy, 1'b0);

        // Timeout: UART never finishes the first byte
        hang_done = 1'b1;
        trig_dly  = 1;
        start_xfer(0, 1);
        wait_end(-1);
        tick();
        chk("to_err_cnt", err_cnt, 1);
        chk("to_done_cnt", done_cnt, 0);
        chk("to_busy", busy_at_err, 1'b0);
        chk("to_latency", err_cyc - (trig_cyc + 1), TO + 1);
        chk("to_wr_cnt", wr_cnt, 1);
        puc_rst_n = 1'b0;
        tick();
        hang_done = 1'b0;
        puc_rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a byte handshake
        trig_dly = 3; done_dly = 3;
        start_xfer(4, 2);
        for (int k = 0; k < 50 && wr_cnt == 0; k++) tick();
        tick();
        chk("mid_busy_pre", busy, 1'b1);
        puc_rst_n = 1'b0;
        #1;
        chk_outs_zero();
        tick();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_err", err_cnt, 0);
        puc_rst_n = 1'b1;
        tick();

        run_xfer($urandom_range(0, DEPTH - 1), 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
